// File: rtl/mem_write_checker.sv
// Self-check monitor on the data-memory write port: classifies each store,
// enforces a cycle timeout and latches a sticky pass/fail verdict.
module mem_write_checker #(
  parameter logic [31:0] PASS_ADR    = 32'd100,
  parameter logic [31:0] PASS_DATA   = 32'd7,
  parameter logic [31:0] SCRATCH_ADR = 32'd96,
  parameter int          TIMEOUT     = 1000,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      Adr,
  input  logic [31:0]      WriteData,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [31:0]      fail_adr,
  output logic [31:0]      fail_data,
  output logic [CNT_W-1:0] write_count,
  output logic [CNT_W-1:0] cycle_count
);

  // Encoding chosen so that the low two bits equal fail_code and bit 2 is pass.
  typedef enum logic [2:0] {
    S_RUN       = 3'b000,
    S_FAIL_ADR  = 3'b001,
    S_FAIL_DATA = 3'b010,
    S_TIMEOUT   = 3'b011,
    S_PASS      = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t state, next_state;
  logic   capture;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (state == S_RUN) begin
      if (MemWrite && Adr == PASS_ADR && WriteData == PASS_DATA)
        next_state = S_PASS;
      else if (MemWrite && Adr == PASS_ADR)
        next_state = S_FAIL_DATA;
      else if (MemWrite && Adr != SCRATCH_ADR)
        next_state = S_FAIL_ADR;
      else if (cycle_count == TO_LAST)
        next_state = S_TIMEOUT;
    end
  end

  always_comb begin
    done      = (state != S_RUN);
    pass      = (state == S_PASS);
    fail_code = state[1:0];
  end

  assign capture = (state == S_RUN) &&
                   (next_state == S_FAIL_ADR || next_state == S_FAIL_DATA);

  // Offending-store capture and counters only move while still running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail_adr    <= '0;
      fail_data   <= '0;
      write_count <= '0;
      cycle_count <= '0;
    end else if (state == S_RUN) begin
      cycle_count <= sat_inc(cycle_count);
      if (MemWrite) write_count <= sat_inc(write_count);
      if (capture) begin
        fail_adr  <= Adr;
        fail_data <= WriteData;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed and randomized bench for mem_write_checker against a behavioural
// verdict model (TIMEOUT shortened to 20 cycles).
module tb_mem_write_checker;

  localparam int TO = 20;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWrite;
  logic [31:0]   Adr;
  logic [31:0]   WriteData;
  logic          done;
  logic          pass;
  logic [1:0]    fail_code;
  logic [31:0]   fail_adr;
  logic [31:0]   fail_data;
  logic [CW-1:0] write_count;
  logic [CW-1:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_done, m_pass;
  logic [1:0]  m_code;
  logic [31:0] m_adr, m_data;
  int          m_wc, m_cc;

  mem_write_checker #(
    .PASS_ADR(32'd100), .PASS_DATA(32'd7), .SCRATCH_ADR(32'd96),
    .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr),
    .WriteData(WriteData), .done(done), .pass(pass), .fail_code(fail_code),
    .fail_adr(fail_adr), .fail_data(fail_data),
    .write_count(write_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_done"},  {31'd0, done},       {31'd0, m_done});
    chk({tag, "_pass"},  {31'd0, pass},       {31'd0, m_pass});
    chk({tag, "_code"},  {30'd0, fail_code},  {30'd0, m_code});
    chk({tag, "_fadr"},  fail_adr,            m_adr);
    chk({tag, "_fdata"}, fail_data,           m_data);
    chk({tag, "_wc"},    {16'd0, write_count}, 32'(m_wc));
    chk({tag, "_cc"},    {16'd0, cycle_count}, 32'(m_cc));
  endtask

  task automatic model_reset();
    m_done = 0; m_pass = 0; m_code = 0; m_adr = 0; m_data = 0; m_wc = 0; m_cc = 0;
  endtask

  // One clock edge of the verdict rules, applied to the sampled store.
  task automatic model_edge(input logic mw, input logic [31:0] a, input logic [31:0] d);
    if (m_done) return;
    m_cc = m_cc + 1;
    if (mw) m_wc = m_wc + 1;
    if (mw && a == 32'd100) begin
      m_done = 1;
      if (d == 32'd7) m_pass = 1;
      else begin m_code = 2'd2; m_adr = a; m_data = d; end
    end else if (mw && a != 32'd96) begin
      m_done = 1; m_code = 2'd1; m_adr = a; m_data = d;
    end else if (m_cc == TO) begin
      m_done = 1; m_code = 2'd3;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input string tag);
    MemWrite = mw; Adr = a; WriteData = d;
    @(posedge clk);
    model_edge(mw, a, d);
    #1;
    chk_all(tag);
    @(negedge clk);
  endtask

  // Reset is raised between clock edges and checked while still held.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    MemWrite = 1'b0;
    model_reset();
    #1;
    chk_all(tag);
    #20;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int nsteps;
    logic mw;
    logic [31:0] a, d;
    reset = 1'b1; MemWrite = 1'b0; Adr = '0; WriteData = '0;
    @(negedge clk);

    // 1: scratch stores then pass; later stores ignored
    do_reset("t1_rst");
    step(1, 32'd96, 32'd3, "t1_s0");
    step(1, 32'd96, 32'd5, "t1_s1");
    step(1, 32'd100, 32'd7, "t1_s2");
    chk("t1_pass_lit", {31'd0, pass}, 32'd1);
    chk("t1_wc_lit", {16'd0, write_count}, 32'd3);
    step(1, 32'd104, 32'd9, "t1_after0");
    step(1, 32'd100, 32'd8, "t1_after1");

    // 2: bad data at pass address
    do_reset("t2_rst");
    step(1, 32'd100, 32'd8, "t2_s0");
    chk("t2_code_lit", {30'd0, fail_code}, 32'd2);
    chk("t2_fdata_lit", fail_data, 32'd8);

    // 3: bad address after a scratch store
    do_reset("t3_rst");
    step(1, 32'd96, 32'd1, "t3_s0");
    step(1, 32'd104, 32'd7, "t3_s1");
    chk("t3_fadr_lit", fail_adr, 32'd104);
    step(1, 32'd100, 32'd7, "t3_frozen");

    // 4: timeout with no stores, random bus contents
    do_reset("t4_rst");
    for (int i = 0; i < TO + 3; i++) step(0, $urandom, $urandom, "t4_idle");
    chk("t4_code_lit", {30'd0, fail_code}, 32'd3);
    chk("t4_cc_lit", {16'd0, cycle_count}, 32'(TO));

    // 5: pass store on the timeout edge wins
    do_reset("t5_rst");
    for (int i = 0; i < TO - 1; i++) step(0, 32'd0, 32'd0, "t5_idle");
    step(1, 32'd100, 32'd7, "t5_edge");
    chk("t5_pass_lit", {31'd0, pass}, 32'd1);

    // 6: reset mid-run
    do_reset("t6_rst0");
    step(1, 32'd96, 32'd11, "t6_s0");
    step(1, 32'd96, 32'd12, "t6_s1");
    do_reset("t6_rst1");
    step(1, 32'd100, 32'd7, "t6_s2");
    chk("t6_wc_lit", {16'd0, write_count}, 32'd1);

    // 7: randomized runs
    for (int r = 0; r < 40; r++) begin
      do_reset("rnd_rst");
      nsteps = $urandom_range(1, TO + 4);
      for (int i = 0; i < nsteps; i++) begin
        mw = ($urandom_range(0, 99) < 40);
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: a = 32'd96;
          6, 7:             a = 32'd100;
          8:                a = 32'd97 + 32'($urandom_range(0, 7));
          default:          a = $urandom;
        endcase
        d = $urandom_range(0, 1) ? 32'd7 : $urandom;
        step(mw, a, d, "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
